// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetch PC, single-outstanding imem request FSM and an in-order prefetch FIFO.
// Optional decode-starvation counter enabled by defining IFU_STALL_CNT_EN.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_halt
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          squash_q, squash_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];

    logic          grant, resp, push, pop;
    logic [31:0]   redirect_target;
    logic          unused_pc_bits;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc[1:0];

    assign grant = (state_q == S_REQ) && imem_gnt;
    assign resp  = (state_q == S_WAIT) && imem_rvalid;
    // A redirect discards both ends of the FIFO in the same cycle.
    assign push  = resp && !squash_q && !redirect;
    assign pop   = dec_valid && dec_ready && !redirect;

    // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (redirect)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        squash_d      = squash_q;
        case (state_q)
            S_IDLE: begin
                if (!fetch_halt && (count_q < DEPTH_C))
                    state_d = S_REQ;
            end
            S_REQ: begin
                // A grant in the redirect cycle is still accepted; its response is squashed.
                if (grant) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    squash_d      = redirect;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    squash_d = 1'b0;
                    state_d  = (!fetch_halt && (count_d < DEPTH_C)) ? S_REQ : S_IDLE;
                end else if (redirect) begin
                    squash_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect)
            fetch_pc_d = redirect_target;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (~rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            count_q       <= count_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; count gates visibility and empty outputs are forced to 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_q]    <= inflight_pc_q;
            buf_instr[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fetch_pc_q;
    assign dec_valid = (count_q != '0);
    assign dec_instr = dec_valid ? buf_instr[rd_ptr_q] : '0;
    assign dec_pc    = dec_valid ? buf_pc[rd_ptr_q] : '0;

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (~rst)
            stall_cnt <= '0;
        else if (dec_ready && !dec_valid && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized memory/decode/redirect traffic against
// an in-order PC-stream scoreboard, plus directed timing and boundary scenarios.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_halt = 1'b0;
`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_halt  (fetch_halt)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    // reference model: the next PC decode must see, and a one-outstanding memory
    logic [31:0] exp_pc;
    int          gnt_pct, mem_lat, mem_cd;
    bit          mem_pend;
    logic [31:0] mem_addr_q;
    int          cyc, n_gnt, n_pop, n_resp, first_valid, exp_stall;
    bit          gnt_seen, pop_seen;
    logic [31:0] last_gnt_addr, last_pop_pc;
    int          pop_cyc[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock: sample and score at negedge, then advance memory model after posedge.
    task automatic cycle();
        bit          g;
        int          lat;
        @(negedge clk);
        gnt_seen = 0;
        pop_seen = 0;
        if (imem_req) begin
            n_vec++;
            if (imem_addr[1:0] !== 2'b00) begin
                n_err++;
                $display("FAIL addr_align: got %h required low bits 00", imem_addr);
            end
        end
        if (!dec_valid) begin
            n_vec++;
            if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
                n_err++;
                $display("FAIL empty_zero: got pc %h instr %h required 0 0", dec_pc, dec_instr);
            end
        end
        if (dec_valid && first_valid < 0) first_valid = cyc;
`ifdef IFU_STALL_CNT_EN
        if (dec_ready && !dec_valid) exp_stall++;
`endif
        if (dec_valid && dec_ready && !redirect) begin
            n_vec++;
            if (dec_pc !== exp_pc || dec_instr !== word_of(exp_pc)) begin
                n_err++;
                $display("FAIL pop_stream: got pc %h instr %h required pc %h instr %h",
                         dec_pc, dec_instr, exp_pc, word_of(exp_pc));
            end
            pop_seen    = 1;
            last_pop_pc = dec_pc;
            n_pop++;
            pop_cyc.push_back(cyc);
            exp_pc      = exp_pc + 32'd4;
        end
        if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
        g = imem_req && imem_gnt;
        if (g) begin
            n_gnt++;
            gnt_seen      = 1;
            last_gnt_addr = imem_addr;
        end
        if (imem_rvalid) n_resp++;
        @(posedge clk);
        #1;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_cd--;
            if (mem_cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mem_addr_q);
                mem_pend    = 0;
            end
        end
        if (g) begin
            lat        = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
            mem_addr_q = last_gnt_addr;
            if (lat == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mem_addr_q);
            end else begin
                mem_pend = 1;
                mem_cd   = lat - 1;
            end
        end
        imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
        cyc++;
    endtask

    task automatic do_reset(input int gp, input int lat, input logic rdy);
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        fetch_halt  = 1'b0;
        dec_ready   = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = 1'b0;
        mem_pend    = 0;
        gnt_pct     = gp;
        mem_lat     = lat;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        imem_gnt    = (int'($urandom_range(0, 99)) < gnt_pct);
        exp_pc      = RESET_PC;
        cyc         = 0;
        n_gnt       = 0;
        n_pop       = 0;
        n_resp      = 0;
        first_valid = -1;
        exp_stall   = 0;
        pop_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || dec_valid !== 1'b0 ||
            dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: got req %b addr %h valid %b instr %h pc %h required 0 %h 0 0 0",
                     imem_req, imem_addr, dec_valid, dec_instr, dec_pc, RESET_PC);
        end
        do_reset(100, 1, 1'b0);
        repeat (10) cycle();
        n_vec++;
        if (dec_valid !== 1'b1) begin
            n_err++;
            $display("FAIL prefill: got dec_valid %b required 1", dec_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL async_reset: got req %b valid %b addr %h required 0 0 %h",
                     imem_req, dec_valid, imem_addr, RESET_PC);
        end
`ifdef IFU_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL stall_reset: got %0d required 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset(100, 1, 1'b1);
        repeat (12) cycle();
        n_vec++;
        if (first_valid != 3) begin
            n_err++;
            $display("FAIL first_valid: got cycle %0d required 3", first_valid);
        end
        n_vec++;
        if (pop_cyc.size() < 3 || pop_cyc[0] != 3 || pop_cyc[1] != 5 || pop_cyc[2] != 7) begin
            n_err++;
            $display("FAIL stream_rate: got %0d pops (first at %0d) required pops at 3,5,7",
                     pop_cyc.size(), (pop_cyc.size() > 0) ? pop_cyc[0] : -1);
        end
    endtask

    task automatic test_fill();
        do_reset(100, 1, 1'b0);
        repeat (20) cycle();
        n_vec++;
        if (n_gnt != DEPTH || imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_err++;
            $display("FAIL fill_full: got grants %0d req %b valid %b pc %h required %0d 0 1 %h",
                     n_gnt, imem_req, dec_valid, dec_pc, DEPTH, RESET_PC);
        end
        dec_ready = 1'b1;
        pop_cyc.delete();
        repeat (20) cycle();
        n_vec++;
        if (pop_cyc.size() < 4 || pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[0] + 2 ||
            pop_cyc[3] != pop_cyc[0] + 3) begin
            n_err++;
            $display("FAIL drain_b2b: got %0d pops required 4 back-to-back", pop_cyc.size());
        end
        n_vec++;
        if (n_gnt <= DEPTH) begin
            n_err++;
            $display("FAIL fetch_resume: got grants %0d required more than %0d", n_gnt, DEPTH);
        end
    endtask

    task automatic test_redirect_squash();
        bit hit = 0;
        do_reset(100, 3, 1'b1);
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = gnt_seen;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL sq_first_grant: got none required a grant within 20 cycles");
        end
        redirect_pc = 32'h0000_0103;
        redirect    = 1'b1;
        cycle();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = gnt_seen;
        end
        n_vec++;
        if (!hit || last_gnt_addr !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL sq_next_addr: got %h (seen %0d) required 00000100", last_gnt_addr, hit);
        end
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = pop_seen;
        end
        n_vec++;
        if (!hit || last_pop_pc !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL sq_next_pc: got %h (seen %0d) required 00000100", last_pop_pc, hit);
        end
    endtask

    task automatic test_redirect_push_pop();
        bit hit = 0;
        do_reset(100, 1, 1'b0);
        for (int i = 0; i < 30 && !hit; i++) begin
            if (n_resp == 2 && imem_rvalid) hit = 1;
            else cycle();
        end
        n_vec++;
        if (!hit || dec_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pp_setup: got valid %b (reached %0d) required 1", dec_valid, hit);
        end
        dec_ready   = 1'b1;
        redirect_pc = 32'h0000_0200;
        redirect    = 1'b1;
        cycle();
        n_vec++;
        if (dec_valid !== 1'b0 || dec_pc !== 32'h0) begin
            n_err++;
            $display("FAIL pp_flush: got valid %b pc %h required 0 0", dec_valid, dec_pc);
        end
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = pop_seen;
        end
        n_vec++;
        if (!hit || last_pop_pc !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL pp_next_pc: got %h (seen %0d) required 00000200", last_pop_pc, hit);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        do_reset(100, 1, 1'b1);
        repeat (4) cycle();
        redirect_pc = 32'hFFFF_FFFE;
        redirect    = 1'b1;
        cycle();
        for (int i = 0; i < 20 && addrs.size() < 2; i++) begin
            cycle();
            if (gnt_seen) addrs.push_back(last_gnt_addr);
        end
        n_vec++;
        if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL pc_wrap: got %0d grants first %h required FFFFFFFC then 00000000",
                     addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hx);
        end
        repeat (6) cycle();
    endtask

    task automatic test_halt();
        bit hit = 0;
        int g0, p0;
        do_reset(100, 2, 1'b1);
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = gnt_seen;
        end
        fetch_halt = 1'b1;
        g0 = n_gnt;
        p0 = n_pop;
        repeat (10) cycle();
        n_vec++;
        if (!hit || n_gnt != g0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL halt_block: got new grants %0d req %b required 0 0", n_gnt - g0, imem_req);
        end
        n_vec++;
        if (n_pop <= p0 || dec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_drain: got pops %0d valid %b required >0 0", n_pop - p0, dec_valid);
        end
`ifdef IFU_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 32'(exp_stall)) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
`endif
        fetch_halt = 1'b0;
    endtask

    task automatic test_random();
        do_reset(70, 0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
            if ($urandom_range(0, 99) < 2) fetch_halt = ~fetch_halt;
            cycle();
        end
        fetch_halt = 1'b0;
        repeat (20) cycle();
        n_vec++;
        if (n_pop < 100) begin
            n_err++;
            $display("FAIL rand_progress: got %0d pops required at least 100", n_pop);
        end
`ifdef IFU_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 32'(exp_stall)) begin
            n_err++;
            $display("FAIL rand_stall_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_squash();
        test_redirect_push_pop();
        test_wrap();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the single-cycle decode/execute core. Holds the fetch PC and issues word-aligned requests to instruction memory over a request/grant/response handshake. Buffers returned instructions with their PCs in a small in-order prefetch FIFO, and presents them to decode with a valid/ready handshake. Branch/jump redirects from the core flush the buffer, squash any in-flight response and restart fetch at the new PC.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset (`negedge rst`, `if(~rst)`).
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  byte address of requested word; [1:0] always 0.
- `imem_gnt`  in  1  memory accepts request this cycle when `imem_req & imem_gnt`.
- `imem_rvalid`  in  1  response data valid; arrives ≥1 cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `dec_valid`  out  1  FIFO head valid.
- `dec_instr`  out  32  head instruction.
- `dec_pc`  out  32  head instruction address.
- `dec_ready`  in  1  decode consumes head when `dec_valid & dec_ready`.
- `redirect`  in  1  one-cycle flush/restart strobe.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced to 0).
- `fetch_halt`  in  1  level; blocks new requests.

## Operation
- State machine, at most one outstanding request:
  - IDLE: `imem_req`=0. Go to REQ when `~fetch_halt` and `count + 0 < DEPTH`.
  - REQ: `imem_req`=1, `imem_addr`=fetch_pc. On grant, latch the granted PC into `inflight_pc`, fetch_pc += 4 (wraps mod 2^32), go to WAIT.
  - WAIT: on `imem_rvalid`, push {inflight_pc, imem_rdata} unless `squash` is set. Go to REQ if not halted and space remains after the push, else IDLE. Clear `squash`.
- Space check counts the outstanding slot: a request is issued only when `count + (state==WAIT) < DEPTH`, so a push never overflows.
- FIFO: circular, pointer wrap mod DEPTH. Simultaneous push and pop is allowed at any occupancy; count is unchanged.
- `dec_valid` = (count != 0). `dec_instr`/`dec_pc` show the head; both are 0 when empty.
- Redirect has priority over every other event in the same cycle:
  - FIFO count is set to 0. A same-cycle pop and push are both discarded.
  - fetch_pc is set to {redirect_pc[31:2], 2'b00}.
  - If in WAIT with no `imem_rvalid` that cycle, set `squash`; stay in WAIT.
  - If in REQ, a same-cycle grant is still treated as accepted (go WAIT, with `squash` set). Otherwise stay in REQ, and `imem_addr` shows the new PC next cycle.
- `fetch_halt` only gates IDLE→REQ and WAIT→REQ. An outstanding response still completes and the FIFO keeps draining. A request already in REQ is not withdrawn.
- Reset mid-operation: all state returns to reset values immediately. The memory's response to a pre-reset grant must not arrive after reset release; this is a system requirement.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0. State IDLE, count 0, `squash` 0.
- First rising edge after reset release: IDLE→REQ.
- Minimum redirect to `dec_valid`:
  - cycle 0: redirect.
  - cycle 1: `imem_req` at the new PC, granted.
  - cycle 2: `imem_rvalid`.
  - cycle 3: `dec_valid`.
  - Total 3 cycles; no bypass from `imem_rdata` to decode.
- Sustained throughput with 1-cycle memory: one instruction per 2 cycles (REQ, WAIT).
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

## Configuration
- `IFU_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` (32 bits, reset 0).
  - Increments each cycle in which `dec_ready`=1 and `dec_valid`=0 (decode starved). Saturates at 32'hFFFF_FFFF.
  - Not cleared by redirect.
- `IFU_STALL_CNT_EN` undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, `dec_ready`=1, memory grants immediately and responds next cycle → PCs 0x0, 0x4, 0x8 emerge in order, one per 2 cycles; first `dec_valid` 3 cycles after reset release.
- `dec_ready`=0 held → exactly DEPTH (4) entries buffered, then `imem_req` stays 0. Raise `dec_ready` → the 4 entries drain in order and fetching resumes.
- Redirect to 0x0000_0103 while in WAIT, response arrives 2 cycles later → that response is dropped. The next request address is 0x0000_0100, and the next `dec_pc` is 0x100.
- Redirect in the same cycle as a push and a pop with the FIFO at 2 entries → `dec_valid`=0 next cycle; no stale PC ever appears.
- fetch_pc 0xFFFF_FFFC → the following request address wraps to 0x0000_0000.
- `fetch_halt`=1 in WAIT → the response is still pushed, no further `imem_req`; the FIFO drains to `dec_valid`=0. With `IFU_STALL_CNT_EN`, `stall_cnt` increments each starved cycle.
